axis_packet_fifo: RTL

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

---
 rtl/axis_packet_fifo.sv | 86 ++++++++
 1 files changed

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: AXI-Stream FIFO with optional store-and-forward packet mode
module axis_packet_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_WIDTH  = 1,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [DATA_WIDTH/8-1:0]   s_tstrb,
  input  logic                      s_tlast,
  input  logic [ID_WIDTH-1:0]       s_tid,
  input  logic [DEST_WIDTH-1:0]     s_tdest,
  input  logic [USER_WIDTH-1:0]     s_tuser,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic [DATA_WIDTH/8-1:0]   m_tstrb,
  output logic                      m_tlast,
  output logic [ID_WIDTH-1:0]       m_tid,
  output logic [DEST_WIDTH-1:0]     m_tdest,
  output logic [USER_WIDTH-1:0]     m_tuser,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      oversize
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam int LB = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int WW = DATA_WIDTH + 2 * KW + 1 + LB;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] rd_word;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, pkt_q, pkt_d;
  logic          rel_q, rel_d, ovs_q, ovs_d;
  logic          wr, rd, rd_last, hold;
  assign rd_word  = mem[rd_ptr_q];
  assign rd_last  = rd_word[LB];
  assign s_tready = !rst && count_q != FULL;
  assign m_tvalid = !rst && count_q != '0 && (PACKET_MODE == 0 || pkt_q != '0 || rel_q);
  assign wr       = s_tvalid && s_tready;
  assign rd       = m_tvalid && m_tready;
  // a full buffer with no complete packet can never emit one, so force it out
  assign hold     = PACKET_MODE != 0 && count_q == FULL && pkt_q == '0 && !rel_q;
  assign {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser} = m_tvalid ? rd_word : '0;
  assign count    = rst ? '0 : count_q;
  assign oversize = !rst && ovs_q;
  // next-state for pointers, occupancy, packet count and forced release
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(rd);
    count_d  = count_q + (AW + 1)'(wr) - (AW + 1)'(rd);
    pkt_d    = pkt_q + (AW + 1)'(wr && s_tlast) - (AW + 1)'(rd && rd_last);
    rel_d    = hold || (rel_q && !(rd && rd_last));
    ovs_d    = hold;
  end
  // storage array, deliberately left without reset
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= {s_tdata, s_tkeep, s_tstrb, s_tlast, s_tid, s_tdest, s_tuser};
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkt_q    <= '0;
      rel_q    <= 1'b0;
      ovs_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
      rel_q    <= rel_d;
      ovs_q    <= ovs_d;
    end
  end
endmodule
